// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, controller state type and round helper functions
package sha256_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, ROUND, UPDATE} state_t;
   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] IV_BUS = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};
   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction
   function automatic logic [31:0] ch(input logic [31:0] e, f, g);
      return (e & f) ^ (~e & g);
   endfunction
   function automatic logic [31:0] maj(input logic [31:0] a, b, c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round on {a..h}
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] st,
   input  logic [31:0]  w_t,
   input  logic [31:0]  k_t,
   output logic [255:0] st_next
);
   logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
   assign {a, b, c, d, e, f, g, h} = st;
   assign t1 = h + bsig1(e) + ch(e, f, g) + k_t + w_t;
   assign t2 = bsig0(a) + maj(a, b, c);
   assign st_next = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: block loader, 64-round sequencer and chained hash state for SHA-256
module sha256_block_ctrl
   import sha256_pkg::*;
(
   input  logic         Clk,
   input  logic         Reset_h,
   input  logic         abort,
   input  logic [31:0]  msg_word,
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic         msg_first,
   input  logic         msg_last,
   output logic         busy,
   output logic [255:0] digest,
   output logic         digest_valid
);
   state_t state;
   logic [511:0] w;
   logic [255:0] v, v_next, h;
   logic [3:0] wcnt;
   logic [5:0] t;
   logic last_q, xfer;
   logic [31:0] w_new;
   // W[i] lives at w[32*i +: 32]; shifting down moves the window one word forward
   assign xfer = msg_valid && msg_ready;
   assign digest = h;
   assign w_new = ssig1(w[479:448]) + w[319:288] + ssig0(w[63:32]) + w[31:0];
   sha256_round u_round (.st(v), .w_t(w[31:0]), .k_t(K[t]), .st_next(v_next));
   always_ff @(posedge Clk or posedge Reset_h)
      if (Reset_h) begin
         state <= IDLE;
         msg_ready <= 1'b1;
         busy <= 1'b0;
         w <= '0;
         v <= '0;
         h <= IV_BUS;
         wcnt <= '0;
         t <= '0;
         last_q <= 1'b0;
         digest_valid <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
         msg_ready <= 1'b1;
         busy <= 1'b0;
         h <= IV_BUS;
         wcnt <= '0;
         t <= '0;
         last_q <= 1'b0;
         digest_valid <= 1'b0;
      end else
         case (state)
            IDLE: if (xfer) begin
               w <= {msg_word, w[511:32]};
               wcnt <= 4'd1;
               state <= LOAD;
               busy <= 1'b1;
               if (msg_first) begin
                  h <= IV_BUS;
                  digest_valid <= 1'b0;
               end
            end
            LOAD: if (xfer) begin
               w <= {msg_word, w[511:32]};
               wcnt <= wcnt + 4'd1;
               if (wcnt == 4'd15) begin
                  last_q <= msg_last;
                  v <= h;
                  t <= '0;
                  state <= ROUND;
                  msg_ready <= 1'b0;
               end
            end
            ROUND: begin
               v <= v_next;
               w <= {w_new, w[511:32]};
               t <= t + 6'd1;
               if (t == 6'd63) state <= UPDATE;
            end
            UPDATE: begin
               for (int i = 0; i < 8; i++) h[32*i +: 32] <= h[32*i +: 32] + v[32*i +: 32];
               digest_valid <= last_q;
               state <= IDLE;
               msg_ready <= 1'b1;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb_sha256_block_ctrl: random and known-answer checks against a message-level SHA-256 model
module tb_sha256_block_ctrl;
   import sha256_pkg::K;
   localparam logic [255:0] H_INIT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   logic Clk = 0, Reset_h = 1, abort = 0, msg_valid = 0, msg_first = 0, msg_last = 0;
   logic [31:0] msg_word = '0;
   logic msg_ready, busy, digest_valid;
   logic [255:0] digest;
   logic [255:0] mh = H_INIT;
   logic mdv = 0;
   logic [31:0] blk [16];
   int n_tests = 0, n_fail = 0;
   sha256_block_ctrl dut (.Clk(Clk), .Reset_h(Reset_h), .abort(abort), .msg_word(msg_word),
      .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_first(msg_first), .msg_last(msg_last),
      .busy(busy), .digest(digest), .digest_valid(digest_valid));
   always #5 Clk = ~Clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] m [16]);
      logic [31:0] ws [64];
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 64; i++)
         if (i < 16) ws[i] = m[i];
         else ws[i] = (rr(ws[i-2], 17) ^ rr(ws[i-2], 19) ^ (ws[i-2] >> 10)) + ws[i-7]
                    + (rr(ws[i-15], 7) ^ rr(ws[i-15], 18) ^ (ws[i-15] >> 3)) + ws[i-16];
      {a, b, c, d, e, f, g, hh} = hin;
      for (int i = 0; i < 64; i++) begin
         t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) | (~e & g)) + K[i] + ws[i];
         t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) | (a & c) | (b & c));
         hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      r = {a, b, c, d, e, f, g, hh};
      for (int j = 0; j < 8; j++) r[32*j +: 32] = r[32*j +: 32] + hin[32*j +: 32];
      return r;
   endfunction
   // called at a negedge; returns at the negedge after the word is taken
   task automatic send_word(input logic [31:0] d, input logic f, input logic l);
      int n = 0;
      msg_word = d; msg_first = f; msg_last = l; msg_valid = 1;
      while (!msg_ready && n < 300) begin
         @(negedge Clk);
         n++;
      end
      if (!msg_ready) check("ready_wait", 256'(msg_ready), 256'd1);
      @(negedge Clk);
      msg_valid = 0;
   endtask
   task automatic run_block(input logic [31:0] m [16], input logic f, input logic l, input bit gaps, input string tag);
      logic dv_pre, dv65 = 1'bx, busy1 = 1'bx;
      int lo = 0;
      if (f) begin
         mh = H_INIT;
         mdv = 0;
      end
      dv_pre = mdv;
      for (int i = 0; i < 16; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge Clk);
         send_word(m[i], i == 0 ? f : 1'($urandom), i == 15 ? l : 1'($urandom));
      end
      msg_valid = gaps; msg_word = 32'hdeadbeef; msg_first = 1; msg_last = 1;
      for (int k = 1; k <= 300 && !msg_ready; k++) begin
         if (k == 1) busy1 = busy;
         if (k == 65) dv65 = digest_valid;
         lo++;
         @(negedge Clk);
      end
      msg_valid = 0;
      mh = compress(mh, m);
      mdv = l;
      check({tag, "_busy_round"}, 256'(busy1), 256'd1);
      check({tag, "_ready_low_cycles"}, 256'(lo), 256'd65);
      check({tag, "_dv_before_update"}, 256'(dv65), 256'(dv_pre));
      check({tag, "_digest"}, digest, mh);
      check({tag, "_digest_valid"}, 256'(digest_valid), 256'(mdv));
      check({tag, "_busy_idle"}, 256'(busy), 256'd0);
   endtask
   task automatic load_abc();
      blk = '{default: 32'h0};
      blk[0] = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask
   task automatic load_empty();
      blk = '{default: 32'h0};
      blk[0] = 32'h80000000;
   endtask
   task automatic check_idle_reset(input string tag);
      check({tag, "_ready"}, 256'(msg_ready), 256'd1);
      check({tag, "_busy"}, 256'(busy), 256'd0);
      check({tag, "_digest"}, digest, H_INIT);
      check({tag, "_dv"}, 256'(digest_valid), 256'd0);
   endtask
   initial begin
      repeat (3) @(negedge Clk);
      Reset_h = 0;
      @(negedge Clk);
      check_idle_reset("reset");
      load_abc();
      run_block(blk, 1, 1, 0, "abc");
      check("abc_kat", digest, ABC);
      load_empty();
      run_block(blk, 1, 1, 0, "empty");
      check("empty_kat", digest, EMPTY);
      blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
              32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      run_block(blk, 1, 0, 0, "two_b1");
      blk = '{default: 32'h0};
      blk[15] = 32'h000001c0;
      run_block(blk, 0, 1, 0, "two_b2");
      check("two_kat", digest, TWO);
      load_abc();
      run_block(blk, 1, 1, 1, "gap_abc");
      check("gap_abc_kat", digest, ABC);
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 16; i++) blk[i] = $urandom;
         run_block(blk, b == 0 || $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), "rand");
      end
      load_abc();
      for (int i = 0; i < 16; i++) send_word(blk[i], i == 0, i == 15);
      repeat (30) @(negedge Clk);
      check("abort_busy", 256'(busy), 256'd1);
      abort = 1;
      @(negedge Clk);
      abort = 0;
      check_idle_reset("abort");
      mh = H_INIT;
      mdv = 0;
      run_block(blk, 1, 1, 0, "post_abort");
      check("post_abort_kat", digest, ABC);
      load_empty();
      for (int i = 0; i < 8; i++) send_word(blk[i], i == 0, 1'b0);
      Reset_h = 1;
      #1;
      check_idle_reset("mid_reset");
      @(negedge Clk);
      Reset_h = 0;
      @(negedge Clk);
      check_idle_reset("post_reset");
      mh = H_INIT;
      mdv = 0;
      run_block(blk, 1, 1, 0, "post_reset_empty");
      check("post_reset_kat", digest, EMPTY);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
